// File: rtl/lightbike_control_hub_pkg.sv
// rtl/lightbike_control_hub_pkg.sv - shared constants, types and helpers for the light-bike control hub
package lightbike_pkg;

  localparam logic [1:0] ORIENT_UP    = 2'd0;
  localparam logic [1:0] ORIENT_RIGHT = 2'd1;
  localparam logic [1:0] ORIENT_DOWN  = 2'd2;
  localparam logic [1:0] ORIENT_LEFT  = 2'd3;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int KEY_ENTRY_W = 9;

  // Listed from player 3 / left down to player 0 / up so p0-d0 lands at bit 0.
  localparam logic [143:0] DEFAULT_KEYMAP = {
    9'h16B, 9'h172, 9'h174, 9'h175,
    9'h03B, 9'h042, 9'h04B, 9'h043,
    9'h02B, 9'h034, 9'h033, 9'h02C,
    9'h01C, 9'h01B, 9'h023, 9'h01D
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lightbike_control_hub_decoder.sv
// rtl/lightbike_control_hub_decoder.sv - PS/2 scancode prefix tracker producing one-cycle make events
module ps2_scancode_decoder
  import lightbike_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear_i,
  input  logic [7:0] key_data_i,
  input  logic       key_pressed_i,
  output logic       make_valid,
  output logic [7:0] make_code,
  output logic       make_ext
);

  ps2_state_e state_q, state_d;

  // Make events are combinational so the steering register updates on the strobe edge.
  always_comb begin
    state_d    = state_q;
    make_valid = 1'b0;
    make_ext   = 1'b0;
    make_code  = key_data_i;
    if (key_pressed_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_data_i == PS2_EXT)      state_d = ST_EXT;
          else if (key_data_i == PS2_BRK) state_d = ST_BRK;
          else                            make_valid = 1'b1;
        end
        ST_EXT: begin
          if (key_data_i == PS2_BRK)      state_d = ST_EXT_BRK;
          else if (key_data_i != PS2_EXT) begin
            make_valid = 1'b1;
            make_ext   = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (clear_i) begin
      state_d    = ST_IDLE;
      make_valid = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

endmodule

// File: rtl/lightbike_control_hub.sv
// rtl/lightbike_control_hub.sv - per-player steering, crash latching and round-end / winner detection
module lightbike_control_hub
  import lightbike_pkg::*;
#(
  parameter int                          NUM_PLAYERS = 4,
  parameter logic [NUM_PLAYERS*36-1:0]   KEYMAP      = DEFAULT_KEYMAP,
  parameter logic [NUM_PLAYERS*2-1:0]    INIT_ORIENT = 8'h2D
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [7:0]                  ps2_key_data,
  input  logic                        ps2_key_pressed,
  input  logic [NUM_PLAYERS-1:0]      active_mask,
  input  logic [NUM_PLAYERS-1:0]      crash,
  input  logic                        round_start,
  output logic [NUM_PLAYERS*32-1:0]   orient_out,
  output logic [NUM_PLAYERS-1:0]      crash_latched,
  output logic [3:0]                  alive_count,
  output logic                        game_over,
  output logic                        game_over_pulse,
  output logic                        winner_valid,
  output logic [2:0]                  winner_id
);

  logic       make_valid, make_ext;
  logic [7:0] make_code;

  ps2_scancode_decoder u_decoder (
    .clock         (clock),
    .resetn        (resetn),
    .clear_i       (round_start),
    .key_data_i    (ps2_key_data),
    .key_pressed_i (ps2_key_pressed),
    .make_valid    (make_valid),
    .make_code     (make_code),
    .make_ext      (make_ext)
  );

  logic [NUM_PLAYERS-1:0] crash_latched_q, crash_latched_d;
  logic [NUM_PLAYERS-1:0] alive_vec;
  logic                   game_over_q, game_over_d;
  logic                   pulse_q, pulse_d;
  logic                   winner_valid_q, winner_valid_d;
  logic [2:0]             winner_id_q, winner_id_d;
  logic [3:0]             alive_cnt, active_cnt;
  logic [2:0]             survivor;
  logic                   end_cond, end_rise;

  assign alive_vec  = active_mask & ~crash_latched_q;
  assign alive_cnt  = popcount8(8'(alive_vec));
  assign active_cnt = popcount8(8'(active_mask));
  // Solo rounds end only once nobody is left; multi-player rounds end at one survivor.
  assign end_cond   = (active_cnt >= 4'd2) ? (alive_cnt <= 4'd1) : (alive_cnt == 4'd0);
  assign end_rise   = ~game_over_q & end_cond;

  always_comb begin
    survivor = 3'd0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (alive_vec[i]) survivor = 3'(i);
    end
  end

  always_comb begin
    crash_latched_d = crash_latched_q | (crash & active_mask & {NUM_PLAYERS{~game_over_q}});
    game_over_d     = game_over_q | end_cond;
    pulse_d         = end_rise;
    winner_valid_d  = winner_valid_q;
    winner_id_d     = winner_id_q;
    if (end_rise) begin
      winner_valid_d = (alive_cnt == 4'd1);
      winner_id_d    = (alive_cnt == 4'd1) ? survivor : 3'd0;
    end
    if (round_start) begin
      crash_latched_d = '0;
      game_over_d     = 1'b0;
      pulse_d         = 1'b0;
      winner_valid_d  = 1'b0;
      winner_id_d     = 3'd0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      crash_latched_q <= '0;
      game_over_q     <= 1'b0;
      pulse_q         <= 1'b0;
      winner_valid_q  <= 1'b0;
      winner_id_q     <= 3'd0;
    end else begin
      crash_latched_q <= crash_latched_d;
      game_over_q     <= game_over_d;
      pulse_q         <= pulse_d;
      winner_valid_q  <= winner_valid_d;
      winner_id_q     <= winner_id_d;
    end
  end

  assign crash_latched   = crash_latched_q;
  assign alive_count     = alive_cnt;
  assign game_over       = game_over_q;
  assign game_over_pulse = pulse_q;
  assign winner_valid    = winner_valid_q;
  assign winner_id       = winner_id_q;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [1:0] orient_q, orient_d;
    logic [1:0] req_dir;
    logic       hit, can_steer;

    // Lowest direction wins if a keymap ever repeats a key within one player.
    always_comb begin
      hit     = 1'b0;
      req_dir = 2'd0;
      for (int d = 3; d >= 0; d--) begin
        if (KEYMAP[(p*4+d)*KEY_ENTRY_W +: KEY_ENTRY_W] == {make_ext, make_code}) begin
          hit     = 1'b1;
          req_dir = 2'(d);
        end
      end
    end

    assign can_steer = make_valid & hit & active_mask[p] & ~crash_latched_q[p] & ~game_over_q
                     & (req_dir != 2'(orient_q + 2'd2));

    always_comb begin
      orient_d = orient_q;
      if (round_start)    orient_d = INIT_ORIENT[p*2 +: 2];
      else if (can_steer) orient_d = req_dir;
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) orient_q <= INIT_ORIENT[p*2 +: 2];
      else         orient_q <= orient_d;
    end

    assign orient_out[p*32 +: 32] = {30'd0, orient_q};
  end

endmodule

// File: tb/tb_lightbike_control_hub.sv
// tb/tb_lightbike_control_hub.sv - directed vector table plus randomized run against a round-level reference model
module tb_lightbike_control_hub;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [7:0]   ps2_key_data = 8'h00;
  logic         ps2_key_pressed = 1'b0;
  logic [3:0]   active_mask = 4'hF;
  logic [3:0]   crash = 4'h0;
  logic         round_start = 1'b0;
  logic [127:0] orient_out;
  logic [3:0]   crash_latched;
  logic [3:0]   alive_count;
  logic         game_over, game_over_pulse, winner_valid;
  logic [2:0]   winner_id;

  lightbike_control_hub #(.NUM_PLAYERS(4)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .active_mask     (active_mask),
    .crash           (crash),
    .round_start     (round_start),
    .orient_out      (orient_out),
    .crash_latched   (crash_latched),
    .alive_count     (alive_count),
    .game_over       (game_over),
    .game_over_pulse (game_over_pulse),
    .winner_valid    (winner_valid),
    .winner_id       (winner_id)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: key table as {ext, code}, indexed [player][direction].
  int km [4][4] = '{'{'h01D, 'h023, 'h01B, 'h01C},
                    '{'h02C, 'h033, 'h034, 'h02B},
                    '{'h043, 'h04B, 'h042, 'h03B},
                    '{'h175, 'h174, 'h172, 'h16B}};
  int init_or [4] = '{1, 3, 2, 0};
  int m_or [4];
  bit [3:0] m_cr;
  bit m_go, m_pulse, m_wv, m_ext, m_rel;
  int m_wid;

  task automatic model_reset();
    for (int p = 0; p < 4; p++) m_or[p] = init_or[p];
    m_cr = 4'h0; m_go = 0; m_pulse = 0; m_wv = 0; m_wid = 0; m_ext = 0; m_rel = 0;
  endtask

  task automatic model_clock(input bit [7:0] d, input bit pr, input bit [3:0] cr,
                             input bit [3:0] act, input bit rs);
    bit [3:0] old_cr;
    bit old_go;
    int n, alive, key;
    if (rs) begin
      model_reset();
      return;
    end
    old_cr = m_cr;
    old_go = m_go;
    n      = $countones(act);
    alive  = $countones(act & ~old_cr);
    if (pr) begin
      if (m_rel) begin
        m_rel = 0; m_ext = 0;
      end else if (d == 8'hE0) begin
        m_ext = 1;
      end else if (d == 8'hF0) begin
        m_rel = 1;
      end else begin
        key = (m_ext ? 256 : 0) + int'(d);
        m_ext = 0;
        for (int p = 0; p < 4; p++) begin
          if (act[p] && !old_cr[p] && !old_go) begin
            for (int dir = 0; dir < 4; dir++) begin
              if (km[p][dir] == key) begin
                if (dir != (m_or[p] + 2) % 4) m_or[p] = dir;
                break;
              end
            end
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) if (cr[i] && act[i] && !old_go) m_cr[i] = 1;
    m_pulse = 0;
    if (!old_go && ((n >= 2 && alive <= 1) || (n < 2 && alive == 0))) begin
      m_go = 1; m_pulse = 1;
      m_wv = (alive == 1);
      m_wid = 0;
      if (alive == 1) for (int i = 0; i < 4; i++) if (act[i] && !old_cr[i]) m_wid = i;
    end
  endtask

  task automatic model_check(input string tag);
    for (int p = 0; p < 4; p++)
      check($sformatf("%s orient%0d", tag, p), orient_out[p*32 +: 32], m_or[p]);
    check({tag, " latched"}, 32'(crash_latched), 32'(m_cr));
    check({tag, " alive"}, 32'(alive_count), $countones(active_mask & ~m_cr));
    check({tag, " game_over"}, 32'(game_over), 32'(m_go));
    check({tag, " pulse"}, 32'(game_over_pulse), 32'(m_pulse));
    check({tag, " winner_valid"}, 32'(winner_valid), 32'(m_wv));
    check({tag, " winner_id"}, 32'(winner_id), m_wid);
  endtask

  function automatic logic [7:0] orient_pack();
    return {orient_out[97:96], orient_out[65:64], orient_out[33:32], orient_out[1:0]};
  endfunction

  task automatic step(input logic [7:0] d, input logic pr, input logic [3:0] cr,
                      input logic [3:0] act, input logic rs);
    ps2_key_data    = d;
    ps2_key_pressed = pr;
    crash           = cr;
    active_mask     = act;
    round_start     = rs;
    @(posedge clock);
    model_clock(d, pr, cr, act, rs);
    #1;
    model_check("model");
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pr;
    logic [3:0] cr;
    logic [3:0] act;
    logic       rs;
    logic [7:0] e_orient;
    logic [3:0] e_alive;
    logic       e_go;
    logic       e_pulse;
    logic       e_wv;
    logic [2:0] e_wid;
  } vec_t;

  vec_t vecs [25];
  logic [7:0] pool [20];

  initial begin
    vecs[0]  = '{8'h00, 1'b0, 4'h0, 4'hF, 1'b0, 8'h2D, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{8'h1D, 1'b1, 4'h0, 4'hF, 1'b0, 8'h2C, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{8'h1B, 1'b1, 4'h0, 4'hF, 1'b0, 8'h2C, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[3]  = '{8'hE0, 1'b1, 4'h0, 4'hF, 1'b0, 8'h2C, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[4]  = '{8'h6B, 1'b1, 4'h0, 4'hF, 1'b0, 8'hEC, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[5]  = '{8'hE0, 1'b1, 4'h0, 4'hF, 1'b0, 8'hEC, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[6]  = '{8'hF0, 1'b1, 4'h0, 4'hF, 1'b0, 8'hEC, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[7]  = '{8'h6B, 1'b1, 4'h0, 4'hF, 1'b0, 8'hEC, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{8'h6B, 1'b1, 4'h0, 4'hF, 1'b0, 8'hEC, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{8'h23, 1'b1, 4'h0, 4'hF, 1'b0, 8'hED, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{8'h00, 1'b0, 4'h2, 4'hF, 1'b0, 8'hED, 4'd3, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[11] = '{8'h00, 1'b0, 4'h0, 4'hF, 1'b0, 8'hED, 4'd3, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[12] = '{8'h00, 1'b0, 4'h4, 4'hF, 1'b0, 8'hED, 4'd2, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[13] = '{8'h00, 1'b0, 4'h0, 4'hF, 1'b0, 8'hED, 4'd2, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[14] = '{8'h00, 1'b0, 4'h1, 4'hF, 1'b0, 8'hED, 4'd1, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[15] = '{8'h00, 1'b0, 4'h0, 4'hF, 1'b0, 8'hED, 4'd1, 1'b1, 1'b1, 1'b1, 3'd3};
    vecs[16] = '{8'h1C, 1'b1, 4'h0, 4'hF, 1'b0, 8'hED, 4'd1, 1'b1, 1'b0, 1'b1, 3'd3};
    vecs[17] = '{8'hE0, 1'b1, 4'h0, 4'hF, 1'b0, 8'hED, 4'd1, 1'b1, 1'b0, 1'b1, 3'd3};
    vecs[18] = '{8'h75, 1'b1, 4'h0, 4'hF, 1'b0, 8'hED, 4'd1, 1'b1, 1'b0, 1'b1, 3'd3};
    vecs[19] = '{8'h00, 1'b0, 4'h4, 4'hF, 1'b1, 8'h2D, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[20] = '{8'h00, 1'b0, 4'h3, 4'h3, 1'b0, 8'h2D, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[21] = '{8'h00, 1'b0, 4'h0, 4'h3, 1'b0, 8'h2D, 4'd0, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[22] = '{8'h00, 1'b0, 4'h0, 4'hF, 1'b1, 8'h2D, 4'd4, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[23] = '{8'h1D, 1'b1, 4'h1, 4'hF, 1'b0, 8'h2C, 4'd3, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[24] = '{8'h23, 1'b1, 4'h0, 4'hF, 1'b0, 8'h2C, 4'd3, 1'b0, 1'b0, 1'b0, 3'd0};

    pool = '{8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h2C, 8'h33, 8'h34, 8'h2B, 8'h43, 8'h4B,
             8'h42, 8'h3B, 8'h75, 8'h74, 8'h72, 8'h6B, 8'hE0, 8'hF0, 8'hE0, 8'hF0};

    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check("reset orient", 32'(orient_pack()), 32'h2D);
    check("reset game_over", 32'(game_over), 32'd0);
    check("reset alive", 32'(alive_count), 32'd4);
    check("reset winner_valid", 32'(winner_valid), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].data, vecs[i].pr, vecs[i].cr, vecs[i].act, vecs[i].rs);
      check($sformatf("vec%0d orient", i), 32'(orient_pack()), 32'(vecs[i].e_orient));
      check($sformatf("vec%0d alive", i), 32'(alive_count), 32'(vecs[i].e_alive));
      check($sformatf("vec%0d game_over", i), 32'(game_over), 32'(vecs[i].e_go));
      check($sformatf("vec%0d pulse", i), 32'(game_over_pulse), 32'(vecs[i].e_pulse));
      check($sformatf("vec%0d winner_valid", i), 32'(winner_valid), 32'(vecs[i].e_wv));
      check($sformatf("vec%0d winner_id", i), 32'(winner_id), 32'(vecs[i].e_wid));
    end

    // Reset in the middle of an extended sequence must drop the pending prefix.
    step(8'hE0, 1'b1, 4'h0, 4'hF, 1'b0);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("async reset orient", 32'(orient_pack()), 32'h2D);
    check("async reset latched", 32'(crash_latched), 32'd0);
    model_check("async reset");
    @(negedge clock);
    resetn = 1'b1;
    step(8'h6B, 1'b1, 4'h0, 4'hF, 1'b0);
    check("post-reset bare 6B", 32'(orient_pack()), 32'h2D);
    step(8'hE0, 1'b1, 4'h0, 4'hF, 1'b0);
    step(8'h6B, 1'b1, 4'h0, 4'hF, 1'b0);
    check("post-reset E0 6B", 32'(orient_pack()), 32'hED);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      logic [3:0] cr, act;
      act = active_mask;
      if ($urandom_range(0, 49) == 0) act = 4'($urandom);
      d  = ($urandom_range(0, 20) == 20) ? 8'($urandom) : pool[$urandom_range(0, 19)];
      cr = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      step(d, ($urandom_range(0, 2) != 0), cr, act, ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
